uart_fifo_tx: RTL

//   Read-side consumer of the 8-bit, 16-deep FIFO buffer. Pops bytes via its
//   rd_en/empty/data_out interface and serialises each one as an asynchronous

---
 rtl/uart_fifo_tx.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/uart_fifo_tx.sv
// uart_fifo_tx
//   Drains an 8-bit FIFO and sends each byte as an asynchronous UART frame:
//   start bit, DATA_W data bits LSB first, optional even-parity bit, one stop
//   bit. Frames are sent back to back while enable is high and the FIFO has
//   data. All outputs are registered.
//
//   Optional feature macro: PARITY_EN (defined -> even parity bit after data).
//
// Ports
//   clk         in   system clock, rising edge
//   rst         in   asynchronous, active-low reset
//   enable      in   1 = new frames may start
//   fifo_empty  in   FIFO empty flag
//   fifo_data   in   FIFO read data, sampled in the FETCH cycle
//   fifo_rd_en  out  one-cycle pop strobe to the FIFO
//   tx          out  serial line, idle high
//   busy        out  high from the pop strobe until the end of the stop bit
//   tx_done     out  one-cycle pulse after the stop bit completes
//
// State   | meaning
// --------+------------------------------------------------------------
// IDLE    | line high; pop when enabled and the FIFO is not empty
// FETCH   | pop strobe visible to the FIFO; latch byte into shifter
// START   | start bit (tx=0)
// DATA    | DATA_W data bits, LSB first
// PARITY  | even parity bit (PARITY_EN builds only)
// STOP    | stop bit (tx=1), then tx_done pulse and back to IDLE

module uart_fifo_tx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_W       = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              fifo_empty,
    input  logic [DATA_W-1:0] fifo_data,
    output logic              fifo_rd_en,
    output logic              tx,
    output logic              busy,
    output logic              tx_done
);

    localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BIT_W  = $clog2(DATA_W) + 1;

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BAUD_W-1:0] BAUD_ONE  = BAUD_W'(1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_W - 1);
    localparam logic [BIT_W-1:0]  BIT_ONE   = BIT_W'(1);

`ifdef PARITY_EN
    typedef enum logic [2:0] {IDLE, FETCH, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [2:0] {IDLE, FETCH, START, DATA, STOP} state_t;
`endif

    state_t             state_q, state_d;
    logic [BAUD_W-1:0]  baud_q, baud_d;
    logic [BIT_W-1:0]   bit_q, bit_d;
    logic [DATA_W-1:0]  shift_q, shift_d;
    logic               tx_d, busy_d, rd_en_d, done_d;
    logic               baud_end;
`ifdef PARITY_EN
    logic               parity_q, parity_d;
`endif

    assign baud_end = (baud_q == BAUD_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            baud_q     <= '0;
            bit_q      <= '0;
            shift_q    <= '0;
            tx         <= 1'b1;
            busy       <= 1'b0;
            fifo_rd_en <= 1'b0;
            tx_done    <= 1'b0;
`ifdef PARITY_EN
            parity_q   <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            baud_q     <= baud_d;
            bit_q      <= bit_d;
            shift_q    <= shift_d;
            tx         <= tx_d;
            busy       <= busy_d;
            fifo_rd_en <= rd_en_d;
            tx_done    <= done_d;
`ifdef PARITY_EN
            parity_q   <= parity_d;
`endif
        end
    end

    // Outputs are registered, so each branch sets the value tx must carry
    // during the next cycle: a bit boundary loads the level of the next bit.
    always_comb begin
        state_d  = state_q;
        baud_d   = baud_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        tx_d     = tx;
        busy_d   = busy;
        rd_en_d  = 1'b0;
        done_d   = 1'b0;
`ifdef PARITY_EN
        parity_d = parity_q;
`endif

        unique case (state_q)
            IDLE: begin
                tx_d   = 1'b1;
                busy_d = 1'b0;
                if (enable && !fifo_empty) begin
                    rd_en_d = 1'b1;
                    busy_d  = 1'b1;
                    state_d = FETCH;
                end
            end

            FETCH: begin
                shift_d  = fifo_data;
`ifdef PARITY_EN
                parity_d = ^fifo_data;
`endif
                baud_d   = '0;
                bit_d    = '0;
                tx_d     = 1'b0;
                state_d  = START;
            end

            START: begin
                baud_d = baud_q + BAUD_ONE;
                if (baud_end) begin
                    baud_d  = '0;
                    tx_d    = shift_q[0];
                    state_d = DATA;
                end
            end

            DATA: begin
                baud_d = baud_q + BAUD_ONE;
                if (baud_end) begin
                    baud_d  = '0;
                    shift_d = {1'b0, shift_q[DATA_W-1:1]};
                    if (bit_q == BIT_LAST) begin
                        bit_d = '0;
`ifdef PARITY_EN
                        tx_d    = parity_q;
                        state_d = PARITY;
`else
                        tx_d    = 1'b1;
                        state_d = STOP;
`endif
                    end else begin
                        bit_d = bit_q + BIT_ONE;
                        tx_d  = shift_q[1];
                    end
                end
            end

`ifdef PARITY_EN
            PARITY: begin
                baud_d = baud_q + BAUD_ONE;
                if (baud_end) begin
                    baud_d  = '0;
                    tx_d    = 1'b1;
                    state_d = STOP;
                end
            end
`endif

            STOP: begin
                baud_d = baud_q + BAUD_ONE;
                if (baud_end) begin
                    baud_d  = '0;
                    tx_d    = 1'b1;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end

            default: begin
                tx_d    = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

endmodule
